// File: rtl/id_ex_stage_pkg.sv
// Shared datapath widths, ALU opcodes and forward-select encodings for the
// ID/EX stage and its forwarding unit.
package id_ex_stage_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    localparam logic [3:0] EXE_ADD          = 4'h0;
    localparam logic [3:0] EXE_SUB          = 4'h1;
    localparam logic [3:0] EXE_AND          = 4'h2;
    localparam logic [3:0] EXE_OR           = 4'h3;
    localparam logic [3:0] EXE_XOR          = 4'h4;
    localparam logic [3:0] EXE_NOR          = 4'h5;
    localparam logic [3:0] EXE_SLT          = 4'h6;
    localparam logic [3:0] EXE_SLL          = 4'h7;
    localparam logic [3:0] EXE_SRL          = 4'h8;
    localparam logic [3:0] EXE_SRA          = 4'h9;
    localparam logic [3:0] EXE_LUI          = 4'hA;
    localparam logic [3:0] EXE_NO_OPERATION = 4'hF;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/id_ex_stage_forward_unit.sv
// Combinational RAW forward-source selection for the two EX operands.
// MEM beats WB; register 0 is never forwarded.
module forward_unit
    import id_ex_stage_pkg::*;
#(
    parameter int REGW = REG_W
) (
    input  logic [REGW-1:0] rs_exe,
    input  logic [REGW-1:0] rt_exe,
    input  logic            regwrite_mem,
    input  logic [REGW-1:0] writereg_mem,
    input  logic            regwrite_wb,
    input  logic [REGW-1:0] writereg_wb,
    output logic [1:0]      fwd_a_sel,
    output logic [1:0]      fwd_b_sel
);

    logic mem_live;
    logic wb_live;

    assign mem_live = regwrite_mem && (writereg_mem != '0);
    assign wb_live  = regwrite_wb  && (writereg_wb  != '0);

    always_comb begin
        fwd_a_sel = FWD_REG;
        if (mem_live && (writereg_mem == rs_exe)) begin
            fwd_a_sel = FWD_MEM;
        end else if (wb_live && (writereg_wb == rs_exe)) begin
            fwd_a_sel = FWD_WB;
        end
    end

    always_comb begin
        fwd_b_sel = FWD_REG;
        if (mem_live && (writereg_mem == rt_exe)) begin
            fwd_b_sel = FWD_MEM;
        end else if (wb_live && (writereg_wb == rt_exe)) begin
            fwd_b_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use stall.
// Drives the EX-stage ALU operands directly.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int REGW  = REG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_id,
    input  logic [WIDTH-1:0] rd1_id,
    input  logic [WIDTH-1:0] rd2_id,
    input  logic [WIDTH-1:0] imm_id,
    input  logic [REGW-1:0]  rs_id,
    input  logic [REGW-1:0]  rt_id,
    input  logic [REGW-1:0]  writereg_id,
    input  logic [4:0]       shamt_id,
    input  logic [3:0]       alucontrol_id,
    input  logic             alusrc_id,
    input  logic             regwrite_id,
    input  logic             memread_id,
    input  logic             memwrite_id,
    input  logic             memtoreg_id,
    input  logic             flush_exe,
    input  logic             regwrite_mem,
    input  logic [REGW-1:0]  writereg_mem,
    input  logic [WIDTH-1:0] aluout_mem,
    input  logic             regwrite_wb,
    input  logic [REGW-1:0]  writereg_wb,
    input  logic [WIDTH-1:0] result_wb,
    output logic             stall_id,
    output logic [WIDTH-1:0] val1,
    output logic [WIDTH-1:0] val2,
    output logic [3:0]       alucontrol_exe,
    output logic [4:0]       shamt_exe,
    output logic [WIDTH-1:0] writedata_exe,
    output logic [REGW-1:0]  writereg_exe,
    output logic             valid_exe,
    output logic             regwrite_exe,
    output logic             memread_exe,
    output logic             memwrite_exe,
    output logic             memtoreg_exe
);

    logic [WIDTH-1:0] rd1_exe;
    logic [WIDTH-1:0] rd2_exe;
    logic [WIDTH-1:0] imm_exe;
    logic [REGW-1:0]  rs_exe;
    logic [REGW-1:0]  rt_exe;
    logic             alusrc_exe;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic [WIDTH-1:0] fwd_a;
    logic [WIDTH-1:0] fwd_b;
    logic             bubble;

    assign stall_id = valid_exe && memread_exe && valid_id && (rt_exe != '0)
                      && ((rt_exe == rs_id) || (rt_exe == rt_id));

    assign bubble = flush_exe || stall_id || !valid_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || bubble) begin
            valid_exe      <= 1'b0;
            rd1_exe        <= '0;
            rd2_exe        <= '0;
            imm_exe        <= '0;
            rs_exe         <= '0;
            rt_exe         <= '0;
            writereg_exe   <= '0;
            shamt_exe      <= '0;
            alucontrol_exe <= EXE_NO_OPERATION;
            alusrc_exe     <= 1'b0;
            regwrite_exe   <= 1'b0;
            memread_exe    <= 1'b0;
            memwrite_exe   <= 1'b0;
            memtoreg_exe   <= 1'b0;
        end else begin
            valid_exe      <= 1'b1;
            rd1_exe        <= rd1_id;
            rd2_exe        <= rd2_id;
            imm_exe        <= imm_id;
            rs_exe         <= rs_id;
            rt_exe         <= rt_id;
            writereg_exe   <= writereg_id;
            shamt_exe      <= shamt_id;
            alucontrol_exe <= alucontrol_id;
            alusrc_exe     <= alusrc_id;
            regwrite_exe   <= regwrite_id;
            memread_exe    <= memread_id;
            memwrite_exe   <= memwrite_id;
            memtoreg_exe   <= memtoreg_id;
        end
    end

    forward_unit #(.REGW(REGW)) u_forward_unit (
        .rs_exe       (rs_exe),
        .rt_exe       (rt_exe),
        .regwrite_mem (regwrite_mem),
        .writereg_mem (writereg_mem),
        .regwrite_wb  (regwrite_wb),
        .writereg_wb  (writereg_wb),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel)
    );

    always_comb begin
        fwd_a = rd1_exe;
        fwd_b = rd2_exe;
        case (fwd_a_sel)
            FWD_MEM: fwd_a = aluout_mem;
            FWD_WB:  fwd_a = result_wb;
            default: fwd_a = rd1_exe;
        endcase
        case (fwd_b_sel)
            FWD_MEM: fwd_b = aluout_mem;
            FWD_WB:  fwd_b = result_wb;
            default: fwd_b = rd2_exe;
        endcase
    end

    // Store data always takes the forwarded rt, even for immediate-operand ops.
    assign val1          = fwd_a;
    assign val2          = alusrc_exe ? imm_exe : fwd_b;
    assign writedata_exe = fwd_b;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus random traffic
// compared against a behavioural model of the EX-stage contents.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_id;
    logic [31:0] rd1_id, rd2_id, imm_id;
    logic [4:0]  rs_id, rt_id, writereg_id, shamt_id;
    logic [3:0]  alucontrol_id;
    logic        alusrc_id, regwrite_id, memread_id, memwrite_id, memtoreg_id;
    logic        flush_exe;
    logic        regwrite_mem, regwrite_wb;
    logic [4:0]  writereg_mem, writereg_wb;
    logic [31:0] aluout_mem, result_wb;

    logic        stall_id;
    logic [31:0] val1, val2, writedata_exe;
    logic [3:0]  alucontrol_exe;
    logic [4:0]  shamt_exe, writereg_exe;
    logic        valid_exe, regwrite_exe, memread_exe, memwrite_exe, memtoreg_exe;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        valid;
        logic [31:0] rd1, rd2, imm;
        logic [4:0]  rs, rt, wr, shamt;
        logic [3:0]  alu;
        logic        alusrc, rw, mr, mw, mtr;
    } ex_t;

    ex_t m;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .valid_id(valid_id),
        .rd1_id(rd1_id), .rd2_id(rd2_id), .imm_id(imm_id),
        .rs_id(rs_id), .rt_id(rt_id), .writereg_id(writereg_id),
        .shamt_id(shamt_id), .alucontrol_id(alucontrol_id),
        .alusrc_id(alusrc_id), .regwrite_id(regwrite_id), .memread_id(memread_id),
        .memwrite_id(memwrite_id), .memtoreg_id(memtoreg_id), .flush_exe(flush_exe),
        .regwrite_mem(regwrite_mem), .writereg_mem(writereg_mem), .aluout_mem(aluout_mem),
        .regwrite_wb(regwrite_wb), .writereg_wb(writereg_wb), .result_wb(result_wb),
        .stall_id(stall_id), .val1(val1), .val2(val2),
        .alucontrol_exe(alucontrol_exe), .shamt_exe(shamt_exe),
        .writedata_exe(writedata_exe), .writereg_exe(writereg_exe),
        .valid_exe(valid_exe), .regwrite_exe(regwrite_exe), .memread_exe(memread_exe),
        .memwrite_exe(memwrite_exe), .memtoreg_exe(memtoreg_exe)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic ex_t bubble_ex();
        ex_t b;
        b = '{valid: 1'b0, rd1: 32'h0, rd2: 32'h0, imm: 32'h0, rs: 5'h0, rt: 5'h0,
              wr: 5'h0, shamt: 5'h0, alu: EXE_NO_OPERATION, alusrc: 1'b0,
              rw: 1'b0, mr: 1'b0, mw: 1'b0, mtr: 1'b0};
        return b;
    endfunction

    // A loaded value in EX is not available yet to an instruction reading it in ID.
    function automatic logic model_stall();
        return m.valid && m.mr && valid_id && (m.rt != 0) && (m.rt == rs_id || m.rt == rt_id);
    endfunction

    // Newest producer wins; $0 is hard-wired and never forwarded.
    function automatic logic [31:0] model_fwd(input logic [4:0] idx, input logic [31:0] regv);
        if (idx == 0) return regv;
        if (regwrite_mem && writereg_mem == idx) return aluout_mem;
        if (regwrite_wb && writereg_wb == idx) return result_wb;
        return regv;
    endfunction

    task automatic model_edge();
        if (flush_exe || model_stall() || !valid_id) begin
            m = bubble_ex();
        end else begin
            m = '{valid: 1'b1, rd1: rd1_id, rd2: rd2_id, imm: imm_id, rs: rs_id, rt: rt_id,
                  wr: writereg_id, shamt: shamt_id, alu: alucontrol_id, alusrc: alusrc_id,
                  rw: regwrite_id, mr: memread_id, mw: memwrite_id, mtr: memtoreg_id};
        end
    endtask

    task automatic check_all();
        logic [31:0] fb;
        #1;
        fb = model_fwd(m.rt, m.rd2);
        chk("stall_id", 32'(stall_id), 32'(model_stall()));
        chk("val1", val1, model_fwd(m.rs, m.rd1));
        chk("val2", val2, m.alusrc ? m.imm : fb);
        chk("writedata", writedata_exe, fb);
        chk("alucontrol", 32'(alucontrol_exe), 32'(m.alu));
        chk("shamt", 32'(shamt_exe), 32'(m.shamt));
        chk("writereg", 32'(writereg_exe), 32'(m.wr));
        chk("ctrl", {27'h0, valid_exe, regwrite_exe, memread_exe, memwrite_exe, memtoreg_exe},
            {27'h0, m.valid, m.rw, m.mr, m.mw, m.mtr});
    endtask

    // Check combinational view, take one edge, land on the next negedge.
    task automatic step();
        check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        valid_id = 0; rd1_id = 0; rd2_id = 0; imm_id = 0; rs_id = 0; rt_id = 0;
        writereg_id = 0; shamt_id = 0; alucontrol_id = EXE_ADD; alusrc_id = 0;
        regwrite_id = 0; memread_id = 0; memwrite_id = 0; memtoreg_id = 0; flush_exe = 0;
        regwrite_mem = 0; writereg_mem = 0; aluout_mem = 0;
        regwrite_wb = 0; writereg_wb = 0; result_wb = 0;
    endtask

    task automatic present_lw_r4();
        idle();
        valid_id = 1; rs_id = 1; rt_id = 4; writereg_id = 4; memread_id = 1;
        regwrite_id = 1; memtoreg_id = 1; alusrc_id = 1; imm_id = 32'h8;
    endtask

    initial begin
        idle();
        rst_n = 0;
        m = bubble_ex();
        repeat (3) @(negedge clk);
        check_all();
        chk("reset_alu", 32'(alucontrol_exe), 32'(EXE_NO_OPERATION));
        rst_n = 1;

        // capture
        valid_id = 1; rd1_id = 5; rd2_id = 7; rs_id = 1; rt_id = 2; writereg_id = 3;
        alucontrol_id = EXE_ADD;
        step();
        idle();
        #1;
        chk("cap_val1", val1, 32'd5);
        chk("cap_val2", val2, 32'd7);
        chk("cap_alu", 32'(alucontrol_exe), 32'(EXE_ADD));
        chk("cap_valid", 32'(valid_exe), 32'd1);
        step();

        // immediate path
        valid_id = 1; alusrc_id = 1; imm_id = 32'hFFFF_FFF0; rd2_id = 9; rt_id = 5;
        alucontrol_id = EXE_OR;
        step();
        idle();
        #1;
        chk("imm_val2", val2, 32'hFFFF_FFF0);
        chk("imm_wdata", writedata_exe, 32'd9);
        step();

        // forward priority
        valid_id = 1; rs_id = 3; rd1_id = 1; rt_id = 6;
        step();
        idle();
        regwrite_mem = 1; writereg_mem = 3; aluout_mem = 32'h11;
        regwrite_wb = 1;  writereg_wb = 3;  result_wb = 32'h22;
        #1 chk("fwd_mem", val1, 32'h11);
        regwrite_mem = 0;
        #1 chk("fwd_wb", val1, 32'h22);
        regwrite_mem = 1; writereg_mem = 0; writereg_wb = 0;
        #1 chk("fwd_r0", val1, 32'd1);
        step();

        // load-use stall, bubble, then capture with WB forwarding
        present_lw_r4();
        step();
        idle();
        valid_id = 1; rs_id = 4; rt_id = 2; rd1_id = 32'h55; writereg_id = 7;
        alucontrol_id = EXE_SUB; regwrite_id = 1;
        #1 chk("lu_stall", 32'(stall_id), 32'd1);
        step();
        #1;
        chk("lu_bubble_valid", 32'(valid_exe), 32'd0);
        chk("lu_bubble_alu", 32'(alucontrol_exe), 32'(EXE_NO_OPERATION));
        chk("lu_stall_drop", 32'(stall_id), 32'd0);
        step();
        idle();
        regwrite_wb = 1; writereg_wb = 4; result_wb = 32'hABC;
        #1 chk("lu_fwd_wb", val1, 32'hABC);
        step();

        // flush together with stall
        present_lw_r4();
        step();
        idle();
        valid_id = 1; rs_id = 0; rt_id = 4; regwrite_id = 1; memwrite_id = 1; flush_exe = 1;
        #1 chk("fl_stall", 32'(stall_id), 32'd1);
        step();
        idle();
        #1;
        chk("fl_rw", 32'(regwrite_exe), 32'd0);
        chk("fl_mw", 32'(memwrite_exe), 32'd0);
        step();

        // async reset mid-stall
        present_lw_r4();
        rd1_id = 32'h77;
        step();
        idle();
        valid_id = 1; rs_id = 4;
        #1 chk("ar_stall_pre", 32'(stall_id), 32'd1);
        rst_n = 0;
        m = bubble_ex();
        #1;
        chk("ar_valid", 32'(valid_exe), 32'd0);
        chk("ar_stall", 32'(stall_id), 32'd0);
        chk("ar_alu", 32'(alucontrol_exe), 32'(EXE_NO_OPERATION));
        chk("ar_val1", val1, 32'd0);
        @(negedge clk);
        rst_n = 1;
        idle();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            valid_id      = ($urandom_range(0, 3) != 0);
            rd1_id        = $urandom;
            rd2_id        = $urandom;
            imm_id        = $urandom;
            rs_id         = 5'($urandom_range(0, 7));
            rt_id         = 5'($urandom_range(0, 7));
            writereg_id   = 5'($urandom_range(0, 7));
            shamt_id      = 5'($urandom);
            alucontrol_id = 4'($urandom_range(0, 10));
            alusrc_id     = 1'($urandom);
            regwrite_id   = 1'($urandom);
            memread_id    = 1'($urandom);
            memwrite_id   = 1'($urandom);
            memtoreg_id   = 1'($urandom);
            flush_exe     = ($urandom_range(0, 7) == 0);
            regwrite_mem  = 1'($urandom);
            writereg_mem  = 5'($urandom_range(0, 7));
            aluout_mem    = $urandom;
            regwrite_wb   = 1'($urandom);
            writereg_wb   = 5'($urandom_range(0, 7));
            result_wb     = $urandom;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
